mdio_master: RTL and testbench

MDIO_MASTER -- requirements
Module: mdio_master

---
 rtl/mdio_pkg.sv | 48 ++++
 rtl/mdio_master_if.sv | 31 +++
 rtl/mdc_gen.sv | 55 +++++
 rtl/mdio_master.sv | 171 +++++++++++++++++
 tb/tb_mdio_master.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// mdio_pkg: shared types and constants for the MDIO (clause 22) management master.
//   mdio_state_e : frame FSM states
//   ST_CODE/OP_* : frame start and opcode fields
//   *_W, *_BITS  : field widths and per-state bit counts
//   last_bit()   : index of the final bit period of a state
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    TA,
    DATA,
    END
  } mdio_state_e;

  localparam logic [1:0] ST_CODE = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;

  localparam int unsigned PHY_W  = 5;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 16;

  localparam int unsigned PRE_BITS  = 32;
  localparam int unsigned HDR_BITS  = 14;
  localparam int unsigned TA_BITS   = 2;
  localparam int unsigned DATA_BITS = 16;

  typedef struct packed {
    logic              op;        // 1 = read
    logic [PHY_W-1:0]  phy_addr;
    logic [REG_W-1:0]  reg_addr;
    logic [DATA_W-1:0] wdata;
  } mdio_cmd_t;

  // END lasts a single bit period, IDLE has no bit count.
  function automatic logic [4:0] last_bit(input mdio_state_e s);
    case (s)
      PRE:     last_bit = 5'(PRE_BITS - 1);
      HDR:     last_bit = 5'(HDR_BITS - 1);
      TA:      last_bit = 5'(TA_BITS - 1);
      DATA:    last_bit = 5'(DATA_BITS - 1);
      default: last_bit = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/mdio_master_if.sv
// mdio_master_if: command/response bus of the MDIO master.
//   cmd_valid/cmd_ready      : command handshake
//   cmd_op/phy/reg/wdata     : command fields (op 1 = read)
//   rsp_valid/rsp_rdata/err  : one-cycle completion with read data and TA fault
//   busy                     : frame in progress
// Modports: master = requester, slave = mdio_master block.
interface mdio_master_if;
  import mdio_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [PHY_W-1:0]  cmd_phy_addr;
  logic [REG_W-1:0]  cmd_reg_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output cmd_valid, cmd_op, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/mdc_gen.sv
// mdc_gen: MDC generator. Low for CLK_DIV cycles, then high for CLK_DIV cycles,
// starting with a low half on the first enabled cycle.
//   sys_clk, rst_n : clock, async active-low reset
//   en             : run enable; when low the counter and mdc are held at 0
//   mdc            : management clock
//   rise_tick      : high on the cycle whose edge takes mdc 0->1
//   fall_tick      : high on the cycle whose edge takes mdc 1->0 (end of bit period)
module mdc_gen #(
  parameter int unsigned CLK_DIV = 40
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic en,
  output logic mdc,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mdc_q, mdc_d;
  logic            term;

  assign term = (cnt_q == CntW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    mdc_d = mdc_q;
    if (!en) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else if (term) begin
      cnt_d = '0;
      mdc_d = ~mdc_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

  assign mdc       = mdc_q;
  assign rise_tick = en & term & ~mdc_q;
  assign fall_tick = en & term & mdc_q;

endmodule

// File: rtl/mdio_master.sv
// mdio_master: clause-22 MDIO management master. Runs one 65-bit-period frame
// (PRE 32, HDR 14, TA 2, DATA 16, END 1) per accepted command.
//   sys_clk, rst_n : clock, async active-low reset
//   bus            : command/response interface (slave modport)
//   mdc            : management clock to the PHY
//   mdio_o/mdio_oe : MDIO data and drive enable for an external tristate
//   mdio_i         : MDIO pad input, already synchronised
module mdio_master
  import mdio_pkg::*;
#(
  parameter int unsigned CLK_DIV = 40
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  mdio_master_if.slave bus,
  output logic         mdc,
  output logic         mdio_o,
  output logic         mdio_oe,
  input  logic         mdio_i
);

  mdio_state_e       state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  mdio_cmd_t         cmd_q, cmd_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              err_q, err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mdio_o_q, mdio_o_d;
  logic              mdio_oe_q, mdio_oe_d;

  logic              idle;
  logic              rise_tick, fall_tick;
  logic              last;
  logic [HDR_BITS-1:0] hdr;
  logic [3:0]        hdr_idx;

  assign idle = (state_q == IDLE);
  assign last = (bit_cnt_q == last_bit(state_q));

  mdc_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_mdc_gen (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .en        (~idle),
    .mdc       (mdc),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Frame sequencing and receive sampling.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    rx_d        = rx_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    if (idle) begin
      if (bus.cmd_valid) begin
        state_d        = PRE;
        bit_cnt_d      = '0;
        cmd_d.op       = bus.cmd_op;
        cmd_d.phy_addr = bus.cmd_phy_addr;
        cmd_d.reg_addr = bus.cmd_reg_addr;
        cmd_d.wdata    = bus.cmd_wdata;
        err_d          = 1'b0;
      end
    end else if (fall_tick) begin
      if (last) begin
        bit_cnt_d = '0;
        case (state_q)
          PRE:  state_d = HDR;
          HDR:  state_d = TA;
          TA:   state_d = DATA;
          DATA: state_d = END;
          default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = cmd_q.op ? rx_q : '0;
            rsp_err_d   = cmd_q.op ? err_q : 1'b0;
          end
        endcase
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end

    // Reads sample the PHY on mdc rising; the PHY drives after mdc falls.
    if (rise_tick && cmd_q.op) begin
      if (state_q == TA && bit_cnt_q == 5'd1) begin
        err_d = mdio_i;
      end
      if (state_q == DATA) begin
        rx_d = {rx_q[DATA_W-2:0], mdio_i};
      end
    end
  end

  // Drive values are decoded from next state, so the registered pins only move
  // on the edges that start a low half (acceptance or mdc falling).
  assign hdr     = {ST_CODE, (cmd_d.op ? OP_RD : OP_WR), cmd_d.phy_addr, cmd_d.reg_addr};
  assign hdr_idx = 4'(HDR_BITS - 1) - bit_cnt_d[3:0];

  always_comb begin
    mdio_o_d  = 1'b1;
    mdio_oe_d = 1'b0;
    case (state_d)
      PRE: begin
        mdio_oe_d = 1'b1;
      end
      HDR: begin
        mdio_o_d  = hdr[hdr_idx];
        mdio_oe_d = 1'b1;
      end
      TA: begin
        if (!cmd_d.op) begin
          mdio_o_d  = (bit_cnt_d == 5'd0);
          mdio_oe_d = 1'b1;
        end
      end
      DATA: begin
        if (!cmd_d.op) begin
          mdio_o_d  = cmd_d.wdata[~bit_cnt_d[3:0]];
          mdio_oe_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      rx_q        <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      rx_q        <= rx_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mdio_o_q    <= mdio_o_d;
      mdio_oe_q   <= mdio_oe_d;
    end
  end

  assign bus.cmd_ready = idle;
  assign bus.busy      = ~idle;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign mdio_o        = mdio_o_q;
  assign mdio_oe       = mdio_oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: CLK_DIV=2 instance with a simple PHY model,
// plus a CLK_DIV=40 instance for MDC timing.
module tb_mdio_master;
  import mdio_pkg::*;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  mdio_master_if bus ();
  mdio_master_if bus40 ();

  logic mdc, mdio_o, mdio_oe;
  logic mdio_i = 1'b1;
  logic mdc40, mdio_o40, mdio_oe40;

  mdio_master #(.CLK_DIV(2)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .mdc     (mdc),
    .mdio_o  (mdio_o),
    .mdio_oe (mdio_oe),
    .mdio_i  (mdio_i)
  );

  mdio_master #(.CLK_DIV(40)) dut40 (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus40),
    .mdc     (mdc40),
    .mdio_o  (mdio_o40),
    .mdio_oe (mdio_oe40),
    .mdio_i  (1'b1)
  );

  int compared   = 0;
  int mismatched = 0;

  // Capture of pin state at each mdc rise, indexed by a running rise count.
  bit cap_o  [0:2047];
  bit cap_oe [0:2047];
  int rise_cnt = 0;
  int base     = 0;

  always @(posedge mdc) begin
    cap_o[rise_cnt % 2048]  = mdio_o;
    cap_oe[rise_cnt % 2048] = mdio_oe;
    rise_cnt++;
  end

  // PHY model: drives on mdc falling; idx is the bit period starting now.
  bit          phy_en   = 1'b1;
  logic [15:0] phy_data = 16'h0141;
  always @(negedge mdc) begin
    int idx;
    idx = rise_cnt - base;
    if (phy_en && idx == 47)                  mdio_i = 1'b0;
    else if (phy_en && idx >= 48 && idx <= 63) mdio_i = phy_data[63 - idx];
    else                                      mdio_i = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic op, input logic [4:0] phy, input logic [4:0] ra,
                       input logic [15:0] wd, input bit hold);
    @(negedge sys_clk);
    bus.cmd_op       = op;
    bus.cmd_phy_addr = phy;
    bus.cmd_reg_addr = ra;
    bus.cmd_wdata    = wd;
    bus.cmd_valid    = 1'b1;
    @(posedge sys_clk);
    #1;
    base = rise_cnt;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge sys_clk);
      #1;
      if (bus.rsp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic logic [63:0] frame_o(input int b);
    logic [63:0] v;
    for (int i = 0; i < 64; i++) v[63 - i] = cap_o[(b + i) % 2048];
    return v;
  endfunction

  function automatic logic [63:0] frame_oe(input int b);
    logic [63:0] v;
    for (int i = 0; i < 64; i++) v[63 - i] = cap_oe[(b + i) % 2048];
    return v;
  endfunction

  localparam logic [63:0] WrFrame = {32'hFFFF_FFFF, 14'b01_01_00001_00000, 2'b10, 16'h8000};
  localparam logic [63:0] RdFrame = {32'hFFFF_FFFF, 14'b01_10_00011_00010, 18'h3FFFF};
  localparam logic [63:0] RdOe    = 64'hFFFF_FFFF_FFFC_0000;

  initial begin
    int lat, wb, pulses, first_r, second_r, high_cnt, rises;
    logic prev;

    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_phy_addr = '0;
    bus.cmd_reg_addr = '0; bus.cmd_wdata = '0;
    bus40.cmd_valid = 1'b0; bus40.cmd_op = 1'b0; bus40.cmd_phy_addr = '0;
    bus40.cmd_reg_addr = '0; bus40.cmd_wdata = '0;

    // Reset state.
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_mdc", 64'(mdc), 64'd0);
    chk("rst_mdio_o", 64'(mdio_o), 64'd1);
    chk("rst_mdio_oe", 64'(mdio_oe), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_err", 64'(bus.rsp_err), 64'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Write phy 1 reg 0 data 8000.
    issue(1'b0, 5'h01, 5'h00, 16'h8000, 1'b0);
    chk("wr_busy", 64'(bus.busy), 64'd1);
    wait_rsp(lat);
    chk("wr_latency", 64'(lat), 64'd260);
    chk("wr_ready_with_rsp", 64'(bus.cmd_ready), 64'd1);
    chk("wr_bits", frame_o(base), WrFrame);
    chk("wr_oe", frame_oe(base), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wr_end_oe", 64'(cap_oe[(base + 64) % 2048]), 64'd0);
    chk("wr_rises", 64'(rise_cnt - base), 64'd65);
    chk("wr_err", 64'(bus.rsp_err), 64'd0);
    chk("wr_rdata", 64'(bus.rsp_rdata), 64'd0);
    @(posedge sys_clk);
    #1;
    chk("wr_pulse_one_cycle", 64'(bus.rsp_valid), 64'd0);

    // Read phy 3 reg 2 with the PHY answering 0141.
    issue(1'b1, 5'h03, 5'h02, 16'hDEAD, 1'b0);
    wait_rsp(lat);
    chk("rd_latency", 64'(lat), 64'd260);
    chk("rd_bits", frame_o(base), RdFrame);
    chk("rd_oe", frame_oe(base), RdOe);
    chk("rd_rdata", 64'(bus.rsp_rdata), 64'h0141);
    chk("rd_err", 64'(bus.rsp_err), 64'd0);
    repeat (5) @(posedge sys_clk);
    #1;
    chk("rd_rdata_hold", 64'(bus.rsp_rdata), 64'h0141);

    // Read with no PHY: pull-up reads as all ones and a TA fault.
    phy_en = 1'b0;
    issue(1'b1, 5'h03, 5'h02, 16'h0000, 1'b0);
    wait_rsp(lat);
    chk("nophy_latency", 64'(lat), 64'd260);
    chk("nophy_rdata", 64'(bus.rsp_rdata), 64'hFFFF);
    chk("nophy_err", 64'(bus.rsp_err), 64'd1);
    phy_en = 1'b1;

    // cmd_valid held through a frame; fields change after acceptance.
    issue(1'b0, 5'h01, 5'h00, 16'h8000, 1'b1);
    wb = base;
    @(negedge sys_clk);
    bus.cmd_op = 1'b1; bus.cmd_phy_addr = 5'h03; bus.cmd_reg_addr = 5'h02;
    wait_rsp(lat);
    chk("b2b_a_latency", 64'(lat), 64'd260);
    chk("b2b_a_ready", 64'(bus.cmd_ready), 64'd1);
    chk("b2b_a_bits", frame_o(wb), WrFrame);
    chk("b2b_a_err", 64'(bus.rsp_err), 64'd0);
    chk("b2b_a_rdata", 64'(bus.rsp_rdata), 64'd0);
    @(posedge sys_clk);
    #1;
    base = rise_cnt;
    bus.cmd_valid = 1'b0;
    chk("b2b_b_accepted", 64'(bus.busy), 64'd1);
    chk("b2b_pulse_one_cycle", 64'(bus.rsp_valid), 64'd0);
    wait_rsp(lat);
    chk("b2b_b_latency", 64'(lat), 64'd260);
    chk("b2b_b_bits", frame_o(base), RdFrame);
    chk("b2b_b_rdata", 64'(bus.rsp_rdata), 64'h0141);

    // Reset during DATA of a write.
    issue(1'b0, 5'h07, 5'h11, 16'hA5A5, 1'b0);
    for (int i = 0; i < 400 && (rise_cnt - base) < 52; i++) @(posedge sys_clk);
    chk("mid_reached_data", 64'((rise_cnt - base) >= 52), 64'd1);
    @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_oe", 64'(mdio_oe), 64'd0);
    chk("mid_rst_mdc", 64'(mdc), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge sys_clk);
      #1;
      if (bus.rsp_valid) pulses++;
    end
    chk("mid_rst_no_rsp", 64'(pulses), 64'd0);
    issue(1'b1, 5'h03, 5'h02, 16'h0000, 1'b0);
    wait_rsp(lat);
    chk("post_rst_latency", 64'(lat), 64'd260);
    chk("post_rst_rdata", 64'(bus.rsp_rdata), 64'h0141);
    chk("post_rst_err", 64'(bus.rsp_err), 64'd0);

    // CLK_DIV=40 write: MDC timing and completion latency.
    @(negedge sys_clk);
    bus40.cmd_phy_addr = 5'h01; bus40.cmd_reg_addr = 5'h00;
    bus40.cmd_wdata = 16'h8000; bus40.cmd_op = 1'b0; bus40.cmd_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    bus40.cmd_valid = 1'b0;
    lat = 0; first_r = 0; second_r = 0; high_cnt = 0; rises = 0; prev = mdc40;
    for (int i = 1; i <= 6000; i++) begin
      @(posedge sys_clk);
      #1;
      if (mdc40 && !prev) begin
        rises++;
        if (rises == 1) first_r = i;
        if (rises == 2) second_r = i;
      end
      if (mdc40) high_cnt++;
      prev = mdc40;
      if (bus40.rsp_valid) begin
        lat = i;
        break;
      end
    end
    chk("div40_latency", 64'(lat), 64'd5200);
    chk("div40_first_rise", 64'(first_r), 64'd40);
    chk("div40_period", 64'(second_r - first_r), 64'd80);
    chk("div40_high_cycles", 64'(high_cnt), 64'd2600);
    chk("div40_rises", 64'(rises), 64'd65);
    chk("div40_err", 64'(bus40.rsp_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
